// File: rtl/pattern_count_engine_if.sv
// Bus bundle for pattern_count_engine.
// Carries the launch handshake (start, pat, pat_mask, busy, done), the three
// result counts, and the data-memory read port (mem_rd_en, mem_addr, mem_rdata).
// modport master : the engine side, which is the memory-read master.
// modport slave  : the core/memory side, which launches runs and serves reads.
interface pattern_count_engine_if #(
  parameter int PAT_W  = 5,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [PAT_W-1:0]  pat;
  logic [PAT_W-1:0]  pat_mask;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  cnt_within;
  logic [CNT_W-1:0]  cnt_bytes;
  logic [CNT_W-1:0]  cnt_stream;

  modport master (
    input  start, pat, pat_mask, mem_rdata,
    output mem_rd_en, mem_addr, busy, done, cnt_within, cnt_bytes, cnt_stream
  );

  modport slave (
    output start, pat, pat_mask, mem_rdata,
    input  mem_rd_en, mem_addr, busy, done, cnt_within, cnt_bytes, cnt_stream
  );
endinterface

// File: rtl/pattern_count_engine.sv
// Bit-pattern search accelerator.
// Streams NBYTES bytes from data memory starting at BASE_ADDR and counts
// masked matches of a PAT_W-bit pattern: inside each byte (cnt_within),
// bytes holding any in-byte match (cnt_bytes), and over the MSB-first
// concatenated stream including byte-crossing windows (cnt_stream).
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - pattern_count_engine_if.master: start/pat/pat_mask in,
//           busy/done/counts out, mem_rd_en/mem_addr out, mem_rdata in
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for start
// S_READ   | issuing one read per cycle, addresses BASE_ADDR..+NBYTES-1
// S_DRAIN  | last byte returning and being accumulated
// S_DONE   | counts valid, done held until next start
module pattern_count_engine #(
  parameter int PAT_W     = 5,
  parameter int NBYTES    = 32,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pattern_count_engine_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int              RC_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(NBYTES - 1);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  logic [1:0]        state;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  mask_q;
  logic [RC_W-1:0]   rd_cnt;
  logic              rd_valid;   // mem_rd_en delayed: mem_rdata holds a byte
  logic              first_byte; // next accumulated byte is byte 0
  logic [PAT_W-2:0]  tail;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  cnt_within;
  logic [CNT_W-1:0]  cnt_bytes;
  logic [CNT_W-1:0]  cnt_stream;

  logic [PAT_W+6:0]  cat;
  logic [3:0]        hits_within;
  logic [3:0]        hits_cross;
  logic [3:0]        hits_stream;

  function automatic logic is_hit(input logic [PAT_W-1:0] w,
                                  input logic [PAT_W-1:0] p,
                                  input logic [PAT_W-1:0] m);
    return ((w ^ p) & ~m) == '0;
  endfunction

  // Byte 0 has no history, so its stream windows are exactly its in-byte
  // windows; later bytes count the 8 windows ending inside the byte.
  always_comb begin
    hits_within = '0;
    hits_cross  = '0;
    cat         = {tail, bus.mem_rdata};
    for (int k = 0; k <= 8 - PAT_W; k++) begin
      if (is_hit(bus.mem_rdata[k +: PAT_W], pat_q, mask_q))
        hits_within = hits_within + 4'd1;
    end
    for (int k = 0; k < 8; k++) begin
      if (is_hit(cat[k +: PAT_W], pat_q, mask_q))
        hits_cross = hits_cross + 4'd1;
    end
    hits_stream = first_byte ? hits_within : hits_cross;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pat_q      <= '0;
      mask_q     <= '0;
      rd_cnt     <= '0;
      rd_valid   <= 1'b0;
      first_byte <= 1'b0;
      tail       <= '0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= BASE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt_within <= '0;
      cnt_bytes  <= '0;
      cnt_stream <= '0;
    end else begin
      rd_valid <= mem_rd_en;

      if (rd_valid) begin
        cnt_within <= cnt_within + CNT_W'(hits_within);
        cnt_bytes  <= cnt_bytes + CNT_W'(hits_within != '0);
        cnt_stream <= cnt_stream + CNT_W'(hits_stream);
        tail       <= cat[PAT_W-2:0];
        first_byte <= 1'b0;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state      <= S_READ;
            pat_q      <= bus.pat;
            mask_q     <= bus.pat_mask;
            cnt_within <= '0;
            cnt_bytes  <= '0;
            cnt_stream <= '0;
            tail       <= '0;
            first_byte <= 1'b1;
            done       <= 1'b0;
            busy       <= 1'b1;
            mem_rd_en  <= 1'b1;
            mem_addr   <= BASE;
            rd_cnt     <= RC_LAST;
          end
        end
        S_READ: begin
          if (rd_cnt == '0) begin
            state     <= S_DRAIN;
            mem_rd_en <= 1'b0;
            mem_addr  <= BASE;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            rd_cnt   <= rd_cnt - 1'b1;
          end
        end
        S_DRAIN: begin
          // Leave only once the final byte has been folded into the counts.
          if (!rd_valid) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en  = mem_rd_en;
  assign bus.mem_addr   = mem_addr;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.cnt_within = cnt_within;
  assign bus.cnt_bytes  = cnt_bytes;
  assign bus.cnt_stream = cnt_stream;

endmodule

// File: doc/pattern_count_engine.md
Name: pattern_count_engine

Overview:
Hardware accelerator for the bit-pattern search kernel. It streams NBYTES bytes out of data memory and compares them against a PAT_W-bit pattern with a per-bit don't-care mask. It produces three counts in one pass: matches inside a byte, bytes with at least one match, and matches anywhere in the concatenated bit stream (byte-crossing allowed). It sits beside the core as a memory-read master with a start/done handshake, so software can replace the loop kernel with a single launch.

Parameters:
PAT_W, 5, pattern width in bits; legal range 2..8.
NBYTES, 32, number of bytes searched; legal range >= 1.
ADDR_W, 8, data memory address width.
BASE_ADDR, 0, address of byte 0 of the search field.
CNT_W, 16, width of each count output; must hold NBYTES*8.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle launch pulse; pat and pat_mask are sampled on the same edge.
pat  in  PAT_W  pattern to search for.
pat_mask  in  PAT_W  1 = don't-care bit; all zeros = exact match.
mem_rd_en  out  1  read strobe to data memory.
mem_addr  out  ADDR_W  read address.
mem_rdata  in  8  read data, valid exactly one cycle after the addressed read.
busy  out  1  high from the cycle after a start is accepted until done rises.
done  out  1  level-high when counts are valid; held until the next accepted start or reset.
cnt_within  out  CNT_W  matches fully inside one byte; max NBYTES*(9-PAT_W).
cnt_bytes  out  CNT_W  bytes containing at least one within-byte match; max NBYTES.
cnt_stream  out  CNT_W  matches over the whole stream; max NBYTES*8-PAT_W+1.

Behaviour:
- Reset (any state): state=IDLE; done=0, busy=0, mem_rd_en=0, mem_addr=BASE_ADDR; all counts=0; internal tail register cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE/DONE --start--> READ: latch pat/pat_mask; clear counts; done<=0.
  - READ: mem_rd_en=1; mem_addr = BASE_ADDR+i for i = 0..NBYTES-1, one per cycle. After the last address, go to DRAIN.
  - DRAIN: accumulate the final byte, then go to DONE.
  - DONE: done=1, busy=0; counts are stable.
- start while busy is ignored.
- Latency: if start is sampled at edge E0, done is first high after edge E0+NBYTES+2.
- Accumulation: byte i is processed in the cycle its mem_rdata is valid, with fully pipelined reads at 1 byte/cycle.
- Match rule for a window w: ((w ^ pat) & ~pat_mask) == 0.
- Within-byte windows: byte[k+PAT_W-1:k] for k = 0..8-PAT_W. Add the number of hits to cnt_within. Increment cnt_bytes by 1 if hits > 0.
- Stream bit order: byte 0 first, MSB first; window p starts at stream bit p.
  - Byte 0: count the 9-PAT_W in-byte windows.
  - Byte i > 0: count the 8 windows of {tail, byte_i} that end inside byte_i, where tail is the last PAT_W-1 bits of the stream so far.
  - Total windows evaluated = NBYTES*8-PAT_W+1.
- Tail register: after each byte, update to the low PAT_W-1 bits of {tail, byte}.
- Arithmetic: counts are unsigned, with no saturation needed under the CNT_W rule. Per-byte popcounts are combinational, max 8 each.
- pat/pat_mask changes after launch have no effect on the run in progress.
- Reset mid-run aborts immediately: mem_rd_en=0 on the next cycle, counts=0, no done pulse.
- start coincident with reset: reset wins.
- NBYTES=1: READ lasts one cycle, the stream count equals the within count, and done is still at E0+3.

Test Plan:
- PAT_W=5, NBYTES=32, all bytes 0x00, pat=00000, mask=0 -> cnt_within=128, cnt_bytes=32, cnt_stream=252; done first high 34 cycles after start; exactly 32 reads, addresses 0..31.
- All bytes 0x55, pat=10101, mask=0 -> cnt_within=64, cnt_bytes=32, cnt_stream=126.
- byte0=0x01, byte1=0xC0, others 0x00, pat=00111 -> cnt_within=0, cnt_bytes=0, cnt_stream=1 (crossing-only detection).
- Random data, pat_mask=11111 -> cnt_within=128, cnt_bytes=32, cnt_stream=252; then change pat mid-run -> results unchanged.
- PAT_W=8, NBYTES=4, bytes {A5,A5,5A,A5}, pat=A5 -> cnt_within=3, cnt_bytes=3, cnt_stream=3; done 6 cycles after start.
- Reset asserted 10 cycles into a run -> next cycle: mem_rd_en=0, done=0, busy=0, counts=0; a subsequent start yields correct counts. start during busy -> ignored, no extra reads.
